// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state type; also used by the parser and TX side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int CLK_FREQ     = 50_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    // Must not collide with any parser command or argument code.
    localparam logic [7:0] IDLE_BYTE = 8'h5A;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2 cycles latency, no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: one-cycle byte strobe (IDLE_BYTE otherwise) landing E0+H+1+9*CLKS_PER_BIT.
// No backpressure: the consumer must take each byte in its strobe cycle.
module uart_rx_byte #(
    parameter int         CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter logic [7:0] IDLE_BYTE    = uart_pkg::IDLE_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [7:0] last_byte,
    output logic       frame_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;

    logic              rx_s;
    uart_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [7:0]        last_q, last_d;
    logic              ferr_q, ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= IDLE_BYTE;
            valid_q <= 1'b0;
            last_q  <= 8'h00;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = IDLE_BYTE;
        valid_d = 1'b0;
        last_d  = last_q;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CW'(H)) begin
                    cnt_d = '0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        last_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not seen as a start bit.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign last_byte  = last_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: serial frames driven bit by bit, strobes compared with a frame-level timing model.
module tb_uart_rx_byte;

    localparam int         CPB        = 16;
    localparam int         H          = (CPB - 1) / 2;
    localparam logic [7:0] IDLE_B     = 8'h5A;
    // 2 synchroniser cycles, 1 edge to notice the start, then H+1 and nine full bits.
    localparam int         STROBE_LAT = 2 + 1 + H + 1 + 9 * CPB;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic [7:0] lb;
    } ev_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic [7:0] last_byte;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         cyc      = 0;
    int         checks   = 0;
    int         passed   = 0;
    int         bad_idle = 0;
    int         both_hi  = 0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    ev_t        ferr_q[$];
    logic       busy_hist [32768];
    logic [7:0] model_last = 8'h00;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .IDLE_BYTE    (IDLE_B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .last_byte  (last_byte),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_hist[cyc[14:0]] = busy;
        if (!reset) begin
            if (data_valid) obs_q.push_back('{cyc, data, last_byte});
            if (frame_err)  ferr_q.push_back('{cyc, data, last_byte});
            if (!data_valid && data !== IDLE_B) bad_idle++;
            if (data_valid && frame_err) both_hi++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, passed=%0d checks=%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles, output int s_o);
        s_o = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, stop_cycles);
        if (stop) begin
            exp_q.push_back('{s_o + STROBE_LAT, b, b});
            model_last = b;
        end
    endtask

    task automatic clear_q;
        obs_q.delete();
        exp_q.delete();
        ferr_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (data !== IDLE_B) $display("FAIL reset_data got=%h exp=%h", data, IDLE_B); else passed++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", data_valid); else passed++;
        checks++; if (last_byte !== 8'h00) $display("FAIL reset_last got=%h exp=00", last_byte); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        model_last = 8'h00;
    endtask

    task automatic test_idle_line;
        int s;
        int busy_hits;
        clear_q();
        s = cyc;
        drive_bit(1'b1, 1000);
        busy_hits = 0;
        for (int c = s + 1; c < s + 1000; c++) if (busy_hist[c] !== 1'b0) busy_hits++;
        checks++; if (obs_q.size() != 0) $display("FAIL idle_valid got=%0d strobes exp=0", obs_q.size()); else passed++;
        checks++; if (ferr_q.size() != 0) $display("FAIL idle_ferr got=%0d strobes exp=0", ferr_q.size()); else passed++;
        checks++; if (bad_idle != 0) $display("FAIL idle_data non-idle cycles got=%0d exp=0", bad_idle); else passed++;
        checks++; if (busy_hits != 0) $display("FAIL idle_busy busy cycles got=%0d exp=0", busy_hits); else passed++;
    endtask

    task automatic test_single;
        int s;
        clear_q();
        send_frame(8'hB0, 1'b1, CPB, s);
        drive_bit(1'b1, 20);
        checks++; if (obs_q.size() != 1) $display("FAIL single_count got=%0d exp=1", obs_q.size()); else passed++;
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].cyc != exp_q[0].cyc) $display("FAIL single_cycle got=%0d exp=%0d", obs_q[0].cyc, exp_q[0].cyc); else passed++;
            checks++; if (obs_q[0].d !== exp_q[0].d) $display("FAIL single_data got=%h exp=%h", obs_q[0].d, exp_q[0].d); else passed++;
            checks++; if (obs_q[0].lb !== exp_q[0].lb) $display("FAIL single_last got=%h exp=%h", obs_q[0].lb, exp_q[0].lb); else passed++;
        end
        checks++; if (ferr_q.size() != 0) $display("FAIL single_ferr got=%0d exp=0", ferr_q.size()); else passed++;
    endtask

    task automatic test_back_to_back;
        int s;
        clear_q();
        send_frame(8'hB1, 1'b1, CPB, s);
        send_frame(8'hFF, 1'b1, CPB, s);
        drive_bit(1'b1, 20);
        checks++; if (obs_q.size() != 2) $display("FAIL b2b_count got=%0d exp=2", obs_q.size()); else passed++;
        if (obs_q.size() >= 2) begin
            checks++; if (obs_q[1].cyc - obs_q[0].cyc != 10 * CPB) $display("FAIL b2b_gap got=%0d exp=%0d", obs_q[1].cyc - obs_q[0].cyc, 10 * CPB); else passed++;
            for (int i = 0; i < 2; i++) begin
                checks++; if (obs_q[i].cyc != exp_q[i].cyc) $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, obs_q[i].cyc, exp_q[i].cyc); else passed++;
                checks++; if (obs_q[i].d !== exp_q[i].d) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, obs_q[i].d, exp_q[i].d); else passed++;
            end
        end
        checks++; if (ferr_q.size() != 0) $display("FAIL b2b_ferr got=%0d exp=0", ferr_q.size()); else passed++;
    endtask

    task automatic test_glitch;
        int s;
        clear_q();
        s = cyc;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 200);
        checks++; if (busy_hist[s + 3] !== 1'b1) $display("FAIL glitch_busy_rise got=%b exp=1", busy_hist[s + 3]); else passed++;
        checks++; if (busy_hist[s + 3 + H + 1] !== 1'b0) $display("FAIL glitch_busy_fall got=%b exp=0", busy_hist[s + 3 + H + 1]); else passed++;
        checks++; if (obs_q.size() != 0) $display("FAIL glitch_valid got=%0d exp=0", obs_q.size()); else passed++;
        checks++; if (ferr_q.size() != 0) $display("FAIL glitch_ferr got=%0d exp=0", ferr_q.size()); else passed++;
    endtask

    task automatic test_bad_stop;
        int         s;
        int         hi;
        logic [7:0] prev;
        clear_q();
        prev = model_last;
        send_frame(8'hAA, 1'b0, 40, s);
        drive_bit(1'b1, 30);
        hi = s + 9 * CPB + 40;
        checks++; if (ferr_q.size() != 1) $display("FAIL badstop_ferr_count got=%0d exp=1", ferr_q.size()); else passed++;
        if (ferr_q.size() >= 1) begin
            checks++; if (ferr_q[0].cyc != s + STROBE_LAT) $display("FAIL badstop_cycle got=%0d exp=%0d", ferr_q[0].cyc, s + STROBE_LAT); else passed++;
            checks++; if (ferr_q[0].lb !== prev) $display("FAIL badstop_last got=%h exp=%h", ferr_q[0].lb, prev); else passed++;
            checks++; if (ferr_q[0].d !== IDLE_B) $display("FAIL badstop_data got=%h exp=%h", ferr_q[0].d, IDLE_B); else passed++;
        end
        checks++; if (obs_q.size() != 0) $display("FAIL badstop_valid got=%0d exp=0", obs_q.size()); else passed++;
        checks++; if (busy_hist[hi + 2] !== 1'b1) $display("FAIL badstop_busy_hold got=%b exp=1", busy_hist[hi + 2]); else passed++;
        checks++; if (busy_hist[hi + 3] !== 1'b0) $display("FAIL badstop_busy_release got=%b exp=0", busy_hist[hi + 3]); else passed++;
        clear_q();
        send_frame(8'hCC, 1'b1, CPB, s);
        drive_bit(1'b1, 20);
        checks++; if (obs_q.size() != 1) $display("FAIL after_bad_count got=%0d exp=1", obs_q.size()); else passed++;
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].d !== 8'hCC) $display("FAIL after_bad_data got=%h exp=cc", obs_q[0].d); else passed++;
            checks++; if (obs_q[0].cyc != exp_q[0].cyc) $display("FAIL after_bad_cycle got=%0d exp=%0d", obs_q[0].cyc, exp_q[0].cyc); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int         s;
        logic [7:0] b;
        clear_q();
        b = 8'($urandom);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], 5);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (data !== IDLE_B) $display("FAIL midrst_data got=%h exp=%h", data, IDLE_B); else passed++;
        checks++; if (data_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", data_valid); else passed++;
        checks++; if (last_byte !== 8'h00) $display("FAIL midrst_last got=%h exp=00", last_byte); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr got=%b exp=0", frame_err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        model_last = 8'h00;
        drive_bit(1'b1, 3 * CPB);
        send_frame(8'h00, 1'b1, CPB, s);
        drive_bit(1'b1, 20);
        checks++; if (obs_q.size() != 1) $display("FAIL midrst_next_count got=%0d exp=1", obs_q.size()); else passed++;
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].d !== 8'h00) $display("FAIL midrst_next_data got=%h exp=00", obs_q[0].d); else passed++;
            checks++; if (obs_q[0].cyc != exp_q[0].cyc) $display("FAIL midrst_next_cycle got=%0d exp=%0d", obs_q[0].cyc, exp_q[0].cyc); else passed++;
        end
    endtask

    task automatic test_random;
        int         s;
        logic [7:0] b;
        clear_q();
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, CPB + int'($urandom_range(0, 24)), s);
        end
        drive_bit(1'b1, 20);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].cyc != exp_q[i].cyc) $display("FAIL rand_cycle[%0d] got=%0d exp=%0d", i, obs_q[i].cyc, exp_q[i].cyc); else passed++;
            checks++; if (obs_q[i].d !== exp_q[i].d) $display("FAIL rand_data[%0d] got=%h exp=%h", i, obs_q[i].d, exp_q[i].d); else passed++;
            checks++; if (obs_q[i].lb !== exp_q[i].lb) $display("FAIL rand_last[%0d] got=%h exp=%h", i, obs_q[i].lb, exp_q[i].lb); else passed++;
        end
        checks++; if (ferr_q.size() != 0) $display("FAIL rand_ferr got=%0d exp=0", ferr_q.size()); else passed++;
    endtask

    task automatic test_global;
        checks++; if (bad_idle != 0) $display("FAIL global_idle_byte non-idle cycles got=%0d exp=0", bad_idle); else passed++;
        checks++; if (both_hi != 0) $display("FAIL global_both_strobes cycles got=%0d exp=0", both_hi); else passed++;
        checks++; if (last_byte !== model_last) $display("FAIL global_last got=%h exp=%h", last_byte, model_last); else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_line();
        test_single();
        test_back_to_back();
        test_glitch();
        test_bad_stop();
        test_reset_mid();
        test_random();
        test_global();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
